// File: rtl/bayer_mosaic_if.sv
// Pixel-in / Bayer-sample-out stream bundle for bayer_mosaic.
// slave is the mosaic block's view, master is the producer/sink side.
interface bayer_mosaic_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pixel;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [10:0] out_addr;
    logic        out_sof;
    logic        out_eol;
    logic        out_eof;

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_data, out_addr, out_sof, out_eol, out_eof
    );

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_data, out_addr, out_sof, out_eol, out_eof
    );
endinterface

// File: rtl/bayer_mosaic.sv
// RGBA raster stream to single-sample Bayer (RGGB) mosaic.
// One output register stage; in_ready is the usual skid-less pass-through
// (ready whenever the output slot is empty or being drained).
module bayer_mosaic #(
    parameter int WIDTH  = 40,
    parameter int HEIGHT = 30
) (
    input  logic           clk,
    input  logic           reset,
    bayer_mosaic_if.slave  s,
    output logic [7:0]     frame_count
);

    logic [5:0]  x;
    logic [4:0]  y;
    logic        accept;
    logic        consume;
    logic        last_x;
    logic        last_y;
    logic [7:0]  sample;
    logic [10:0] addr;
    logic        unused_alpha;

    // Alpha carries no information for the mosaic.
    assign unused_alpha = ^s.in_pixel[7:0];

    assign s.in_ready = !reset && (!s.out_valid || s.out_ready);
    assign accept     = s.in_valid && s.in_ready;
    assign consume    = s.out_valid && s.out_ready;
    assign last_x     = (x == 6'(WIDTH - 1));
    assign last_y     = (y == 5'(HEIGHT - 1));
    assign addr       = 11'(y) * 11'(WIDTH) + 11'(x);

    // Pick the colour channel for the RGGB site at (x, y).
    always_comb begin
        sample = s.in_pixel[23:16];
        case ({x[0], y[0]})
            2'b00:   sample = s.in_pixel[31:24];
            2'b11:   sample = s.in_pixel[15:8];
            default: sample = s.in_pixel[23:16];
        endcase
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            if (last_x) begin
                x <= '0;
                y <= last_y ? '0 : y + 5'd1;
            end else begin
                x <= x + 6'd1;
            end
        end
    end

    // Output register: load on accept, empty when drained with nothing behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
            s.out_addr  <= '0;
            s.out_sof   <= 1'b0;
            s.out_eol   <= 1'b0;
            s.out_eof   <= 1'b0;
        end else if (accept) begin
            s.out_valid <= 1'b1;
            s.out_data  <= sample;
            s.out_addr  <= addr;
            s.out_sof   <= (x == '0) && (y == '0);
            s.out_eol   <= last_x;
            s.out_eof   <= last_x && last_y;
        end else if (consume) begin
            s.out_valid <= 1'b0;
        end
    end

    // Frames count when the final sample leaves, not when it enters.
    always_ff @(posedge clk) begin
        if (reset) frame_count <= '0;
        else if (consume && s.out_eof) frame_count <= frame_count + 8'd1;
    end

endmodule

// File: tb/tb_bayer_mosaic.sv
// Randomized bench for bayer_mosaic with a queue-based reference model.
module tb_bayer_mosaic;
    localparam int W  = 40;
    localparam int H  = 30;
    localparam int W2 = 4;
    localparam int H2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    logic [7:0] fc, fc2;

    bayer_mosaic_if b();
    bayer_mosaic_if sb();

    bayer_mosaic #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .reset(rst), .s(b), .frame_count(fc)
    );
    bayer_mosaic #(.WIDTH(W2), .HEIGHT(H2)) dut_small (
        .clk(clk), .reset(rst2), .s(sb), .frame_count(fc2)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [10:0] addr;
        logic        sof, eol, eof;
    } samp_t;

    samp_t q[$];
    int    pos    = 0;
    int    exp_fc = 0;

    function automatic samp_t model(input int p, input logic [31:0] px);
        samp_t s;
        int xx, yy;
        xx = p % W;
        yy = p / W;
        if (xx % 2 == 0 && yy % 2 == 0)      s.data = px[31:24];
        else if (xx % 2 == 1 && yy % 2 == 1) s.data = px[15:8];
        else                                 s.data = px[23:16];
        s.addr = 11'(p);
        s.sof  = (p == 0);
        s.eol  = (xx == W - 1);
        s.eof  = (p == W * H - 1);
        return s;
    endfunction

    // Compare outputs against the model mid-cycle, then advance the model
    // by what the coming rising edge will do with the now-stable inputs.
    always @(negedge clk) begin
        bit mv, er, cons, acc;
        mv = (q.size() != 0);
        er = !rst && (!mv || b.out_ready);
        chk("in_ready", 32'(b.in_ready), 32'(er));
        chk("out_valid", 32'(b.out_valid), 32'(mv));
        if (mv) begin
            chk("out_data", 32'(b.out_data), 32'(q[0].data));
            chk("out_addr", 32'(b.out_addr), 32'(q[0].addr));
            chk("out_sof", 32'(b.out_sof), 32'(q[0].sof));
            chk("out_eol", 32'(b.out_eol), 32'(q[0].eol));
            chk("out_eof", 32'(b.out_eof), 32'(q[0].eof));
        end
        chk("frame_count", 32'(fc), 32'(exp_fc));
        if (rst) begin
            q.delete();
            pos    = 0;
            exp_fc = 0;
        end else begin
            cons = mv && b.out_ready;
            acc  = b.in_valid && er;
            if (cons) begin
                if (q[0].eof) exp_fc = (exp_fc + 1) % 256;
                void'(q.pop_front());
            end
            if (acc) begin
                q.push_back(model(pos, b.in_pixel));
                pos = (pos + 1) % (W * H);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            b.in_valid  = ($urandom % 4) != 0;
            b.out_ready = ($urandom % 4) != 0;
            b.in_pixel  = $urandom;
            step();
        end
    endtask

    initial begin
        logic [10:0] held_addr;
        logic [7:0]  held_data;
        int          guard;

        b.in_valid = 1'b0; b.out_ready = 1'b0; b.in_pixel = '0;
        sb.in_valid = 1'b0; sb.out_ready = 1'b0; sb.in_pixel = '0;

        // Reset state
        repeat (3) step();
        chk("rst_out_valid", 32'(b.out_valid), 0);
        chk("rst_in_ready", 32'(b.in_ready), 0);
        chk("rst_out_data", 32'(b.out_data), 0);
        chk("rst_out_addr", 32'(b.out_addr), 0);
        chk("rst_flags", 32'({b.out_sof, b.out_eol, b.out_eof}), 0);
        chk("rst_fc", 32'(fc), 0);
        rst = 1'b0;

        // First pixel: red site
        b.in_valid = 1'b1; b.out_ready = 1'b1; b.in_pixel = 32'h11223344;
        step();
        chk("px0_valid", 32'(b.out_valid), 1);
        chk("px0_data", 32'(b.out_data), 32'h11);
        chk("px0_addr", 32'(b.out_addr), 0);
        chk("px0_sof", 32'(b.out_sof), 1);

        // Remainder of frame 0, back-to-back
        for (int k = 1; k < W * H; k++) begin
            b.in_pixel = {8'hA0, 8'hB0, 8'hC0, 8'($urandom)};
            step();
            chk("stream_valid", 32'(b.out_valid), 1);
            if (k == 1)  chk("addr1_g", 32'(b.out_data), 32'hB0);
            if (k == 40) chk("addr40_g", 32'(b.out_data), 32'hB0);
            if (k == 41) chk("addr41_b", 32'(b.out_data), 32'hC0);
            if (k == 39) chk("eol39", 32'(b.out_eol), 1);
            if (k == W * H - 1) begin
                chk("eof_1199", 32'(b.out_eof), 1);
                chk("fc_before_consume", 32'(fc), 0);
            end
        end
        b.in_valid = 1'b0;
        step();
        chk("fc_after_frame", 32'(fc), 1);
        chk("drained", 32'(b.out_valid), 0);

        // Backpressure: one held sample, inputs refused, fields stable
        b.in_valid = 1'b1; b.in_pixel = $urandom;
        step();
        b.out_ready = 1'b0;
        held_addr = b.out_addr;
        held_data = b.out_data;
        for (int i = 0; i < 5; i++) begin
            b.in_pixel = $urandom;
            step();
            chk("stall_in_ready", 32'(b.in_ready), 0);
            chk("stall_addr", 32'(b.out_addr), 32'(held_addr));
            chk("stall_data", 32'(b.out_data), 32'(held_data));
        end
        b.out_ready = 1'b1;
        step();
        chk("release_addr", 32'(b.out_addr), 32'(held_addr) + 1);

        rand_phase(3000);

        // Mid-frame reset at address 617
        b.in_valid = 1'b1; b.out_ready = 1'b1;
        guard = 0;
        while (!(b.out_valid && b.out_addr == 11'd617) && guard < 3000) begin
            b.in_pixel = $urandom;
            step();
            guard++;
        end
        if (guard >= 3000) chk("reach_617", 0, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        b.in_pixel = 32'h55667788;
        step();
        chk("post_rst_addr", 32'(b.out_addr), 0);
        chk("post_rst_sof", 32'(b.out_sof), 1);
        chk("post_rst_data", 32'(b.out_data), 32'h55);
        chk("post_rst_fc", 32'(fc), 0);

        rand_phase(2000);
        b.in_valid = 1'b0;

        // Small frame instance: frame counter wrap over 256 frames
        step();
        rst2 = 1'b0;
        sb.in_valid = 1'b1; sb.out_ready = 1'b1;
        for (int k = 1; k <= 256 * W2 * H2 + 1; k++) begin
            sb.in_pixel = $urandom;
            step();
            chk("small_addr", 32'(sb.out_addr), 32'((k - 1) % (W2 * H2)));
            chk("small_sof", 32'(sb.out_sof), 32'(((k - 1) % (W2 * H2)) == 0));
            chk("small_fc", 32'(fc2), 32'(((k - 1) / (W2 * H2)) % 256));
            if (k == 256 * W2 * H2) chk("fc_255", 32'(fc2), 255);
            if (k == 256 * W2 * H2 + 1) begin
                chk("fc_wrap0", 32'(fc2), 0);
                chk("wrap_sof", 32'(sb.out_sof), 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bayer_mosaic.md
BAYER_MOSAIC -- requirements
Module: bayer_mosaic

Interface
REQ-001 Parameter WIDTH, default 40, SHALL be the frame width in pixels.
REQ-002 Parameter HEIGHT, default 30, SHALL be the frame height in pixels.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 Port in_valid  input  1  SHALL flag that in_pixel holds a valid RGBA pixel.
REQ-006 Port in_ready  output  1  SHALL flag that the block accepts in_pixel this cycle.
REQ-007 Port in_pixel  input  32  SHALL carry an rgba_t pixel: r [31:24], g [23:16], b [15:8], a [7:0].
REQ-008 Port out_valid  output  1  SHALL flag that the out_* fields hold a valid mosaic sample.
REQ-009 Port out_ready  input  1  SHALL flag that the downstream sink accepts the sample this cycle.
REQ-010 Port out_data  output  8  SHALL carry the single Bayer sample for the current pixel.
REQ-011 Port out_addr  output  11  SHALL carry the raster address y*WIDTH+x of the sample.
REQ-012 Port out_sof  output  1  SHALL mark the sample at x=0, y=0.
REQ-013 Port out_eol  output  1  SHALL mark the sample at x=WIDTH-1.
REQ-014 Port out_eof  output  1  SHALL mark the sample at x=WIDTH-1, y=HEIGHT-1.
REQ-015 Port frame_count  output  8  SHALL count completed frames and wrap from 255 to 0.

Function
REQ-016 A pixel SHALL be accepted when in_valid and in_ready are both high on a rising edge.
REQ-017 A sample SHALL be consumed when out_valid and out_ready are both high on a rising edge.
REQ-018 in_ready SHALL be combinational: high when out_valid is low or out_ready is high.
REQ-019 The block SHALL hold one output register stage; an accepted pixel SHALL appear on out_* on the next cycle (latency 1).
REQ-020 With in_valid and out_ready held high, the block SHALL sustain one sample per cycle with no bubbles.
REQ-021 While out_valid is high and out_ready is low, all out_* fields SHALL hold stable and no input SHALL be accepted.
REQ-022 When a sample is consumed and no pixel is accepted that cycle, out_valid SHALL fall on the next cycle.
REQ-023 Internal counters x (6 bit) and y (5 bit) SHALL track the position of the next accepted pixel.
REQ-024 On acceptance, x SHALL increment; at x=WIDTH-1, x SHALL wrap to 0 and y SHALL increment.
REQ-025 At x=WIDTH-1 and y=HEIGHT-1, both x and y SHALL wrap to 0 on acceptance.
REQ-026 Colour selection from {x[0],y[0]} SHALL be: 00 -> r, 10 -> g (green beside red), 01 -> g (green beside blue), 11 -> b.
REQ-027 The alpha byte SHALL be ignored.
REQ-028 out_addr SHALL be computed as y*WIDTH+x in 11 bits, with no truncation for WIDTH*HEIGHT <= 2048.
REQ-029 frame_count SHALL increment on the cycle the sample with out_eof=1 is consumed, not when it is accepted.
REQ-030 The block SHALL keep no other state: there are no idle or stall states beyond the output register occupancy.

Reset
REQ-031 While reset is high: x=0, y=0, out_valid=0, frame_count=0, and out_data, out_addr, out_sof, out_eol, out_eof = 0.
REQ-032 While reset is high, in_ready SHALL be low.
REQ-033 Reset asserted mid-frame SHALL discard the held sample and the position; the next accepted pixel after reset SHALL be x=0, y=0 with out_sof=1.
REQ-034 An in_valid or out_ready asserted in the same cycle as reset SHALL have no effect.

Verification
REQ-035 Reset, then stream pixel 0 = 32'h11223344 with out_ready=1 -> one cycle later out_valid=1, out_data=8'h11, out_addr=0, out_sof=1.
REQ-036 Stream pixels 1, 40 and 41, each with r=8'hA0, g=8'hB0, b=8'hC0 -> out_data=B0 (addr 1), B0 (addr 40), C0 (addr 41).
REQ-037 Stream a full 1200-pixel frame with out_ready=1 -> 1200 back-to-back samples; out_eol on addr 39, 79, ..., 1199; out_eof only on addr 1199; frame_count 0 -> 1 one cycle after the final sample is consumed.
REQ-038 Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0; out_* stable; exactly one pixel held; no pixel lost or duplicated after release.
REQ-039 Assert reset at addr 617 for one cycle, then resume -> first post-reset sample has out_addr=0, out_sof=1, frame_count=0.
REQ-040 Run 256 frames -> frame_count wraps from 255 to 0; second frame's first sample has out_addr=0, out_sof=1.
